ofmap_deskew_collector: RTL
===========================

Name: ofmap_deskew_collector

Overview:
- Sits directly downstream of the MAC array and consumes its per-column ofmap_valid/ofmap_data streams.
- Column c's result for a given ifmap row arrives skewed in time relative to column 0, and the array cannot stall.
- The block buffers each column in its own FIFO and re-aligns the columns into full MAC_COL-wide row vectors.
- It emits those vectors over a valid/ready handshake, counts rows per tile, and flags overflow.

Parameters:
- MAC_COL, 16, number of array columns / output lanes
- OFMAP_BITWIDTH, 32, width of each partial-sum lane (two's complement)
- FIFO_DEPTH, 32, entries per column FIFO; power of two, >= 2*MAC_COL
- TILE_ROWS, 16, output rows per tile; tile_done pulses after this many pops

Ports:
- clk  in  1  clock
- rstn  in  1  synchronous active-low reset
- clear_in  in  1  synchronous flush: pointers, row counter, overflow flag
- ofmap_valid_in  in  MAC_COL  per-column valid from the array
- ofmap_data_in  in  MAC_COL x OFMAP_BITWIDTH  per-column data from the array
- out_valid  out  1  aligned row vector available
- out_ready  in  1  consumer accepts the vector
- out_data  out  MAC_COL x OFMAP_BITWIDTH  aligned row vector; lane c = column c
- tile_done_out  out  1  one-cycle pulse after the TILE_ROWS-th pop of a tile
- overflow_out  out  1  sticky; a column write was dropped

Behaviour:
- Interface (already decided): one clock, clk; reset rstn is synchronous and active-low.
- Reset: all FIFO pointers and counts = 0; row counter = 0; out_valid = 0; out_data = 0; tile_done_out = 0; overflow_out = 0. Reset mid-operation discards all buffered data.
- Write: on a cycle with ofmap_valid_in[c]=1, column FIFO c writes ofmap_data_in[c], provided it is not full or is popped in the same cycle.
- Write onto a full FIFO with no pop: data dropped, and overflow_out goes to 1 from the next cycle. It stays 1 until rstn or clear_in.
- Visibility: a word written at edge t is visible at that FIFO's head from cycle t+1. No bypass.
- out_valid = AND over all columns of FIFO non-empty, decoded from registered counts.
- out_data = FIFO heads when out_valid=1; forced to 0 when out_valid=0.
- Pop: when out_valid & out_ready, every column FIFO advances by one entry simultaneously.
- Simultaneous push and pop on one FIFO: count unchanged; both the push and the pop take effect, including when the FIFO is full.
- Pointer wrap: modulo FIFO_DEPTH. Count is $clog2(FIFO_DEPTH)+1 bits wide, so full and empty are distinguished.
- Row counter: 0..TILE_ROWS-1, incremented on each pop.
- Tile end: a pop with counter = TILE_ROWS-1 wraps the counter to 0 and registers tile_done_out = 1 for exactly the next cycle.
- clear_in: takes priority over same-cycle writes and pops. It empties all FIFOs and zeroes the row counter and overflow_out. It does not touch storage contents, and suppresses a tile_done_out that would otherwise arise that cycle.
- out_valid and out_data have no combinational path from out_ready.
- Data is passed unmodified, with no width change, unless the optional feature is enabled.

Optional Feature:
- Macro: OFMAP_RELU_EN.
- Defined: each out_data lane whose head MSB is 1 (negative) is output as 0. Applied combinationally on the head after the valid gating; buffered contents are unchanged.
- Undefined: lanes pass through bit-exact.

Decomposition:
- Shared package mac_pkg:
  - MAC_COL, OFMAP_BITWIDTH defaults
  - typedef ofmap_t = logic [OFMAP_BITWIDTH-1:0]
  - typedef ofmap_vec_t = ofmap_t [MAC_COL-1:0]
- Sub-module ofmap_col_fifo, instantiated MAC_COL times via generate:
  - inputs: push, pop, din
  - outputs: dout (head), empty, full
  - internals: single-clock register storage, synchronous active-low reset
- Top level holds the empty-AND, row counter, tile_done register, overflow flag and the ReLU stage.

Test Plan:
- Aligned input: all 16 columns valid in cycle 0 with lane c = c. Expect out_valid=1 in cycle 1, out_data lane c = c, and a pop with out_ready=1.
- Skewed input: column c valid only in cycle c, data 0x100+c. Expect out_valid=0 through cycle 15 and out_valid=1 in cycle 16 with lanes 0x100..0x10F.
- Backpressure: out_ready=0 while 32 aligned rows are written. Expect all FIFOs full, overflow_out=0, and pops then return rows in order 0..31.
- Overflow: write a 33rd row with no pop. Expect overflow_out=1 next cycle and stays 1; the 33rd row is never output. Assert clear_in: overflow_out=0, out_valid=0.
- Tile count: TILE_ROWS=16, 20 aligned rows, out_ready=1. Expect exactly one tile_done_out pulse, in the cycle after the 16th pop, and row counter = 4 at the end.
- OFMAP_RELU_EN defined: lanes 0xFFFFFFFF and 0x00000005. Expect out_data 0x0 and 0x5; undefined: expect 0xFFFFFFFF and 0x5.

Source files
------------

// File: rtl/mac_pkg.sv
// Shared MAC-array types and default sizes.
// Used by the ofmap collector and its column FIFOs.
package mac_pkg;

  localparam int MAC_COL        = 16;
  localparam int OFMAP_BITWIDTH = 32;
  localparam int FIFO_DEPTH     = 32;
  localparam int TILE_ROWS      = 16;

  typedef logic [OFMAP_BITWIDTH-1:0] ofmap_t;
  typedef ofmap_t [MAC_COL-1:0]      ofmap_vec_t;

endpackage

// File: rtl/ofmap_col_fifo.sv
// Single-column ofmap FIFO: register storage, head always visible on dout.
// Ports: clk, rstn (sync, active-low), clear, push, pop, din -> dout, empty, full.
module ofmap_col_fifo
  import mac_pkg::*;
#(
  parameter int DEPTH = FIFO_DEPTH,
  parameter int W     = OFMAP_BITWIDTH
) (
  input  logic         clk,
  input  logic         rstn,
  input  logic         clear,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout,
  output logic         empty,
  output logic         full
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wptr;
  logic [AW-1:0] rptr;
  logic [AW:0]   cnt;
  logic          wr;

  // A full FIFO still accepts a push when it is popped the same cycle.
  assign wr    = push & (~full | pop);
  assign empty = (cnt == '0);
  assign full  = (cnt == FULL_CNT);
  assign dout  = mem[rptr];

  always_ff @(posedge clk) begin
    if (!rstn) begin
      wptr <= '0;
      rptr <= '0;
      cnt  <= '0;
    end else if (clear) begin
      wptr <= '0;
      rptr <= '0;
      cnt  <= '0;
    end else begin
      if (wr)
        wptr <= wptr + 1'b1;
      if (pop)
        rptr <= rptr + 1'b1;
      unique case ({wr, pop})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rstn && !clear && wr)
      mem[wptr] <= din;
  end

endmodule

// File: rtl/ofmap_deskew_collector.sv
// Re-aligns skewed per-column MAC outputs into row vectors with valid/ready.
// Ports: clk, rstn, clear_in, ofmap_valid_in/data_in in; out_valid/out_data/
// out_ready handshake; tile_done_out pulse; sticky overflow_out.
// Optional: OFMAP_RELU_EN zeroes negative output lanes.
module ofmap_deskew_collector
  import mac_pkg::*;
#(
  parameter int MAC_COL_P    = mac_pkg::MAC_COL,
  parameter int W            = mac_pkg::OFMAP_BITWIDTH,
  parameter int DEPTH        = mac_pkg::FIFO_DEPTH,
  parameter int TILE_ROWS_P  = mac_pkg::TILE_ROWS
) (
  input  logic                   clk,
  input  logic                   rstn,
  input  logic                   clear_in,
  input  logic [MAC_COL_P-1:0]   ofmap_valid_in,
  input  logic [MAC_COL_P*W-1:0] ofmap_data_in,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [MAC_COL_P*W-1:0] out_data,
  output logic                   tile_done_out,
  output logic                   overflow_out
);

  localparam int RW = (TILE_ROWS_P > 1) ? $clog2(TILE_ROWS_P) : 1;
  localparam logic [RW-1:0] LAST = RW'(TILE_ROWS_P - 1);

  logic [MAC_COL_P-1:0]   empty;
  logic [MAC_COL_P-1:0]   full;
  logic [MAC_COL_P-1:0]   drop;
  logic [MAC_COL_P*W-1:0] head;
  logic                   pop;
  logic                   last_row;
  logic [RW-1:0]          row_cnt;

  for (genvar c = 0; c < MAC_COL_P; c++) begin : g_col
    ofmap_col_fifo #(
      .DEPTH (DEPTH),
      .W     (W)
    ) u_fifo (
      .clk   (clk),
      .rstn  (rstn),
      .clear (clear_in),
      .push  (ofmap_valid_in[c]),
      .pop   (pop),
      .din   (ofmap_data_in[c*W +: W]),
      .dout  (head[c*W +: W]),
      .empty (empty[c]),
      .full  (full[c])
    );
  end

  assign out_valid = ~|empty;
  assign pop       = out_valid & out_ready;
  assign drop      = ofmap_valid_in & full & {MAC_COL_P{~pop}};
  assign last_row  = (row_cnt == LAST);

  always_comb begin
    out_data = '0;
    for (int c = 0; c < MAC_COL_P; c++) begin
      if (out_valid)
        out_data[c*W +: W] = head[c*W +: W];
`ifdef OFMAP_RELU_EN
      if (out_data[c*W + W - 1])
        out_data[c*W +: W] = '0;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      row_cnt       <= '0;
      tile_done_out <= 1'b0;
      overflow_out  <= 1'b0;
    end else if (clear_in) begin
      row_cnt       <= '0;
      tile_done_out <= 1'b0;
      overflow_out  <= 1'b0;
    end else begin
      tile_done_out <= pop & last_row;
      if (pop)
        row_cnt <= last_row ? '0 : row_cnt + 1'b1;
      if (|drop)
        overflow_out <= 1'b1;
    end
  end

endmodule
